// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, programmable read/write wait states.
// Latency: ready pulses LAT edges after the request is sampled (1 edge for rejected requests).
// Backpressure: requests are only sampled in IDLE; a request held high through ready starts a new access.
module mem_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  op_write;
    logic                  op_fault;
    logic                  range_bad;
    logic                  req_fault;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Any address bit above the word index means the access falls outside the store.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_range
        assign range_bad = |addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_norange
        assign range_bad = 1'b0;
    end

    assign req_fault = (mem_read & mem_write) | (addr[1:0] != 2'b00) | range_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
            op_fault <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            ready <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        busy     <= 1'b1;
                        idx      <= addr[IDX_W+1:2];
                        wdata_q  <= wdata;
                        op_write <= mem_write;
                        op_fault <= req_fault;
                        if (req_fault) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else if (mem_write) begin
                            cnt   <= WR_LOAD;
                            state <= (WRITE_LATENCY == 1) ? DONE : WAIT;
                        end else begin
                            cnt   <= RD_LOAD;
                            state <= (READ_LATENCY == 1) ? DONE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Completion edge: data moves, ready rises and busy drops together.
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    fault <= op_fault;
                    if (!op_fault && !op_write) begin
                        rdata <= mem[idx];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; a reset forces state to IDLE so a pending write never lands.
    assign mem_we = (state == DONE) && op_write && !op_fault && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expectations, negedge monitor checks every ready pulse.
module tb_mem_responder;

    localparam int RL    = 2;
    localparam int WL    = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        fault;

    mem_responder #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = '0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_fault(input bit rd, input bit wr, input logic [31:0] a);
        return (rd && wr) || (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    endfunction

    // Issue at a negedge; returns at the negedge where ready is visible (request still driven).
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble);
        exp_t e;
        bit   f;
        int   lat;
        int   n;
        f   = is_fault(rd, wr, a);
        lat = f ? 1 : (wr ? WL : RL);
        if (!f && wr) model[a >> 2] = d;
        if (!f && rd) last_rd = model[a >> 2];
        e.rdata = last_rd;
        e.fault = f;
        e.cyc   = cyc + 1 + lat;
        sb.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
        if (scramble) begin
            addr  = $urandom;
            wdata = $urandom;
        end
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_seen", 32'(ready), 32'd1);
    endtask

    task automatic release_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
    endtask

    bit prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (ready) begin
                check("ready_width", 32'(prev_ready), 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: got ready with no pending request (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("fault", 32'(fault), 32'(e.fault));
                    check("rdata", rdata, e.rdata);
                    check("ready_cycle", cyc, e.cyc);
                    check("busy_at_ready", 32'(busy), 32'd0);
                end
            end
            prev_ready = ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read.
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        release_req();
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        release_req();

        // Misaligned and out-of-range reads are rejected without touching rdata.
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        release_req();
        do_req(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
        release_req();

        // Simultaneous read and write is rejected; prior contents survive.
        do_req(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0);
        release_req();
        do_req(1'b1, 1'b1, 32'h20, 32'h1234, 1'b0);
        release_req();
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        release_req();

        // Reset one cycle after accepting a write aborts it.
        do_req(1'b0, 1'b1, 32'h30, 32'hA5A50001, 1'b0);
        release_req();
        mem_write = 1'b1;
        addr      = 32'h30;
        wdata     = 32'h55;
        @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rdata", rdata, 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fault", 32'(fault), 32'd0);
        last_rd   = '0;
        mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        release_req();

        // Back-to-back reads with the request held through ready.
        do_req(1'b0, 1'b1, 32'h0, 32'h11110000, 1'b0);
        release_req();
        do_req(1'b0, 1'b1, 32'h4, 32'h22220004, 1'b0);
        release_req();
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        release_req();

        // Random traffic over the first 16 words, all pre-initialised.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);
            if ($urandom_range(0, 1) == 0) release_req();
        end
        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic [31:0] a;
            bit          scr;
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            scr  = ($urandom_range(0, 2) == 0);
            if (kind < 4) begin
                do_req(1'b0, 1'b1, a, $urandom, scr);
            end else if (kind < 8) begin
                do_req(1'b1, 1'b0, a, $urandom, scr);
            end else if (kind == 8) begin
                do_req(1'b1, 1'b1, a, $urandom, scr);
            end else if ($urandom_range(0, 1) == 0) begin
                do_req(1'b1, 1'b0, a + 32'($urandom_range(1, 3)), $urandom, scr);
            end else begin
                do_req(1'b0, 1'b1, 32'h400 + (32'($urandom_range(0, 1000)) << 2), $urandom, scr);
            end
            if ($urandom_range(0, 1) == 0) release_req();
        end
        release_req();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
